// File: rtl/issue_queue_if.sv
// Dispatch, wakeup, kill and issue signals shared by the issue queue and its
// neighbours. The master side is dispatch/writeback; the slave side is the queue.
interface issue_queue_if #(
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_TAG = 5,
  parameter int WIDTH_BRM = 3,
  parameter int WIDTH_PRY = 2,
  parameter int DEPTH     = 8,
  parameter int WAKE_N    = 4
);
  localparam int WIDTH_E = WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + WIDTH_PRY;
  localparam int WIDTH_O = WIDTH_BRM + WIDTH_TAG + 2 + 3*WIDTH_REG;
  localparam int CW      = $clog2(DEPTH+1);

  logic                        disp_val;
  logic [WIDTH_E-1:0]          disp_data;
  logic                        disp_p1;
  logic                        disp_p2;
  logic                        disp_rdy;
  logic [WAKE_N-1:0]           wval;
  logic [WAKE_N*WIDTH_REG-1:0] wdest;
  logic [2**WIDTH_BRM-1:0]     brkill;
  logic                        stall;
  logic                        iss_val;
  logic [WIDTH_O-1:0]          iss_data;
  logic [CW-1:0]               count;

  modport master (
    output disp_val, disp_data, disp_p1, disp_p2, wval, wdest, brkill, stall,
    input  disp_rdy, iss_val, iss_data, count
  );

  modport slave (
    input  disp_val, disp_data, disp_p1, disp_p2, wval, wdest, brkill, stall,
    output disp_rdy, iss_val, iss_data, count
  );
endinterface

// File: rtl/issue_queue.sv
// Multi-slot issue queue: operand wakeup, priority-then-age select into a
// registered issue stage with stall hold, and branch-kill flushing.
module issue_queue #(
  parameter int         WIDTH_REG = 5,
  parameter int         WIDTH_TAG = 5,
  parameter int         WIDTH_BRM = 3,
  parameter int         WIDTH_PRY = 2,
  parameter int         DEPTH     = 8,
  parameter int         WAKE_N    = 4,
  parameter logic [1:0] TAG_BANK  = 2'b00,
  parameter int         WIDTH_E   = WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + WIDTH_PRY,
  parameter int         WIDTH_O   = WIDTH_BRM + WIDTH_TAG + 2 + 3*WIDTH_REG
) (
  input logic         clk,
  input logic         rst_n,
  issue_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [WIDTH_BRM-1:0] br;
    logic [WIDTH_TAG-1:0] tag;
    logic [WIDTH_REG-1:0] rd;
    logic [WIDTH_REG-1:0] rs2;
    logic [WIDTH_REG-1:0] rs1;
    logic [WIDTH_PRY-1:0] pry;
  } uop_t;

  logic [DEPTH-1:0] val, p1, p2;
  uop_t             ent [DEPTH];
  logic [DEPTH-1:0] age [DEPTH];
  logic [CW-1:0]    count;
  logic             iss_val;
  logic [WIDTH_O-1:0] iss_data;

  uop_t             disp;
  logic [DEPTH-1:0] kill, cand, win_oh, wk1, wk2;
  logic [IW-1:0]    win_idx, alloc_idx;
  logic             any_win, sel_en, issue, disp_rdy, accept, dwk1, dwk2;
  logic [CW-1:0]    kill_cnt, count_next;
  uop_t             win_uop;

  function automatic logic hit(input logic [WAKE_N-1:0] wv,
                               input logic [WAKE_N*WIDTH_REG-1:0] wd,
                               input logic [WIDTH_REG-1:0] r);
    hit = 1'b0;
    for (int w = 0; w < WAKE_N; w++)
      if (wv[w] && wd[w*WIDTH_REG +: WIDTH_REG] == r) hit = 1'b1;
  endfunction

  assign disp = bus.disp_data;

  always_comb begin
    kill      = '0;
    cand      = '0;
    win_oh    = '0;
    wk1       = '0;
    wk2       = '0;
    win_idx   = '0;
    alloc_idx = '0;
    kill_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = val[i] & bus.brkill[ent[i].br];
      cand[i] = val[i] & p1[i] & p2[i] & ~kill[i];
      wk1[i]  = hit(bus.wval, bus.wdest, ent[i].rs1);
      wk2[i]  = hit(bus.wval, bus.wdest, ent[i].rs2);
      kill_cnt = kill_cnt + CW'(kill[i]);
    end
    // A candidate wins if no other candidate has higher priority, or equal priority and greater age
    for (int i = 0; i < DEPTH; i++) begin
      win_oh[i] = cand[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && cand[j] &&
            (ent[j].pry > ent[i].pry || (ent[j].pry == ent[i].pry && !age[i][j])))
          win_oh[i] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++)
      if (win_oh[i]) win_idx = IW'(i);
    for (int i = DEPTH-1; i >= 0; i--)
      if (!val[i]) alloc_idx = IW'(i);
    any_win    = |win_oh;
    win_uop    = ent[win_idx];
    sel_en     = !iss_val || !bus.stall;
    issue      = sel_en && any_win;
    disp_rdy   = count < CW'(DEPTH);
    accept     = bus.disp_val && disp_rdy && !bus.brkill[disp.br];
    dwk1       = bus.disp_p1 | hit(bus.wval, bus.wdest, disp.rs1);
    dwk2       = bus.disp_p2 | hit(bus.wval, bus.wdest, disp.rs2);
    count_next = count + CW'(accept) - CW'(issue) - kill_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val      <= '0;
      count    <= '0;
      iss_val  <= 1'b0;
      iss_data <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      count <= count_next;
      for (int i = 0; i < DEPTH; i++)
        if (kill[i] || (issue && win_oh[i])) val[i] <= 1'b0;
      if (accept) begin
        val[alloc_idx] <= 1'b1;
        for (int j = 0; j < DEPTH; j++) age[j][alloc_idx] <= val[j];
        age[alloc_idx] <= '0;
      end
      // A stalled, held op is still subject to branch kill
      if (sel_en) begin
        iss_val <= any_win;
        if (any_win)
          iss_data <= {win_uop.br, win_uop.tag, TAG_BANK, win_uop.rd, win_uop.rs2, win_uop.rs1};
      end else if (iss_val && bus.brkill[iss_data[WIDTH_O-1 -: WIDTH_BRM]]) begin
        iss_val <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (val[i] && wk1[i]) p1[i] <= 1'b1;
      if (val[i] && wk2[i]) p2[i] <= 1'b1;
    end
    if (accept) begin
      ent[alloc_idx] <= disp;
      p1[alloc_idx]  <= dwk1;
      p2[alloc_idx]  <= dwk2;
    end
  end

  assign bus.disp_rdy = disp_rdy;
  assign bus.iss_val  = iss_val;
  assign bus.iss_data = iss_data;
  assign bus.count    = count;
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: an ordered-list model of the queue is checked
// every cycle, alongside literal expectations for each scenario.
module tb_issue_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  issue_queue_if bus ();
  issue_queue dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] br;
    logic [4:0] tag, rd, rs2, rs1;
    logic [1:0] pry;
    bit p1, p2;
  } ent_t;

  ent_t        q[$];
  ent_t        nq[$];
  bit          m_val = 1'b0;
  logic [24:0] m_data = '0;

  function automatic logic [24:0] word(input logic [2:0] br, input logic [4:0] tag,
                                       input logic [4:0] rd, input logic [4:0] rs2,
                                       input logic [4:0] rs1);
    return {br, tag, 2'b00, rd, rs2, rs1};
  endfunction

  function automatic bit woke(input logic [4:0] r);
    for (int w = 0; w < 4; w++)
      if (bus.wval[w] && bus.wdest[w*5 +: 5] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue kept oldest-first; the winner is the first entry with strictly highest priority
  task automatic model_step();
    int          win;
    bit          sel;
    ent_t        e;
    logic [24:0] d;
    d   = bus.disp_data;
    sel = !m_val || !bus.stall;
    win = -1;
    if (sel)
      foreach (q[i])
        if (q[i].p1 && q[i].p2 && !bus.brkill[q[i].br] && (win < 0 || q[i].pry > q[win].pry))
          win = i;
    if (sel) begin
      m_val = (win >= 0);
      if (win >= 0) m_data = word(q[win].br, q[win].tag, q[win].rd, q[win].rs2, q[win].rs1);
    end else if (m_val && bus.brkill[m_data[24:22]]) begin
      m_val = 1'b0;
    end
    nq.delete();
    foreach (q[i])
      if (i != win && !bus.brkill[q[i].br]) begin
        e = q[i];
        e.p1 = e.p1 | woke(e.rs1);
        e.p2 = e.p2 | woke(e.rs2);
        nq.push_back(e);
      end
    if (bus.disp_val && q.size() < 8 && !bus.brkill[d[24:22]]) begin
      e.br  = d[24:22];
      e.tag = d[21:17];
      e.rd  = d[16:12];
      e.rs2 = d[11:7];
      e.rs1 = d[6:2];
      e.pry = d[1:0];
      e.p1  = bus.disp_p1 | woke(e.rs1);
      e.p2  = bus.disp_p2 | woke(e.rs2);
      nq.push_back(e);
    end
    q = nq;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_val  = 1'b0;
      m_data = '0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_iss_val", 32'(bus.iss_val), 32'(m_val));
      if (m_val) check("model_iss_data", 32'(bus.iss_data), 32'(m_data));
      check("model_count", 32'(bus.count), 32'(q.size()));
      check("model_disp_rdy", 32'(bus.disp_rdy), 32'(q.size() < 8));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.disp_val  = 1'b0;
    bus.disp_data = '0;
    bus.disp_p1   = 1'b0;
    bus.disp_p2   = 1'b0;
    bus.wval      = '0;
    bus.wdest     = '0;
    bus.brkill    = '0;
  endtask

  task automatic applyStimulus(input logic [2:0] br, input logic [4:0] tag, input logic [4:0] rd,
                               input logic [4:0] rs2, input logic [4:0] rs1, input logic [1:0] pry,
                               input logic p1, input logic p2);
    bus.disp_val  = 1'b1;
    bus.disp_data = {br, tag, rd, rs2, rs1, pry};
    bus.disp_p1   = p1;
    bus.disp_p2   = p2;
  endtask

  task automatic wake(input int port, input logic [4:0] tag);
    bus.wval[port]          = 1'b1;
    bus.wdest[port*5 +: 5]  = tag;
  endtask

  task automatic checkOutput(input string name, input logic val, input logic [4:0] tag);
    check({name, "_val"}, 32'(bus.iss_val), 32'(val));
    if (val) check({name, "_tag"}, 32'(bus.iss_data[21:17]), 32'(tag));
  endtask

  initial begin
    bus.stall = 1'b0;
    idle();
    repeat (2) tick();
    check("rst_iss_val", 32'(bus.iss_val), 0);
    check("rst_iss_data", 32'(bus.iss_data), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_disp_rdy", 32'(bus.disp_rdy), 1);
    #2 rst_n = 1'b1;
    tick();

    // Two-step wakeup on different ports
    applyStimulus(3'd0, 5'd1, 5'd5, 5'd4, 5'd3, 2'd0, 1'b0, 1'b0);
    tick(); idle();
    check("t1_count1", 32'(bus.count), 1);
    tick();
    wake(0, 5'd3); tick(); idle();
    tick();
    wake(3, 5'd4); tick(); idle();
    checkOutput("t1_not_yet", 1'b0, 5'd0);
    tick();
    checkOutput("t1_issue", 1'b1, 5'd1);
    check("t1_data", 32'(bus.iss_data), 32'(word(3'd0, 5'd1, 5'd5, 5'd4, 5'd3)));
    check("t1_count0", 32'(bus.count), 0);
    tick();

    // Priority first, then age
    applyStimulus(3'd0, 5'd2, 5'd6, 5'd9, 5'd1, 2'd1, 1'b1, 1'b0); tick();
    applyStimulus(3'd0, 5'd3, 5'd7, 5'd9, 5'd2, 2'd3, 1'b1, 1'b0); tick();
    applyStimulus(3'd0, 5'd4, 5'd8, 5'd9, 5'd3, 2'd1, 1'b1, 1'b0); tick();
    idle();
    check("t2_count3", 32'(bus.count), 3);
    wake(2, 5'd9); tick(); idle();
    tick(); checkOutput("t2_first_B", 1'b1, 5'd3);
    tick(); checkOutput("t2_second_A", 1'b1, 5'd2);
    tick(); checkOutput("t2_third_C", 1'b1, 5'd4);
    tick(); checkOutput("t2_drained", 1'b0, 5'd0);

    // Fill behind a stalled output, then drain in age order
    applyStimulus(3'd0, 5'd5, 5'd1, 5'd1, 5'd1, 2'd0, 1'b1, 1'b1);
    tick(); idle();
    bus.stall = 1'b1;
    tick(); checkOutput("t3_held", 1'b1, 5'd5);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(3'd0, 5'(8 + k), 5'd2, 5'd2, 5'd2, 2'd0, 1'b1, 1'b1);
      tick();
    end
    idle();
    check("t3_full_count", 32'(bus.count), 8);
    check("t3_full_rdy", 32'(bus.disp_rdy), 0);
    checkOutput("t3_still_held", 1'b1, 5'd5);
    applyStimulus(3'd0, 5'd16, 5'd2, 5'd2, 5'd2, 2'd3, 1'b1, 1'b1);
    tick(); idle();
    check("t3_ninth_ignored", 32'(bus.count), 8);
    bus.stall = 1'b0;
    applyStimulus(3'd0, 5'd17, 5'd2, 5'd2, 5'd2, 2'd3, 1'b1, 1'b1);
    check("t3_rdy_low_on_issue", 32'(bus.disp_rdy), 0);
    tick(); idle();
    check("t3_count7", 32'(bus.count), 7);
    checkOutput("t3_drain0", 1'b1, 5'd8);
    for (int k = 1; k < 8; k++) begin
      tick();
      checkOutput("t3_drain", 1'b1, 5'(8 + k));
    end
    tick(); checkOutput("t3_empty", 1'b0, 5'd0);

    // Multi-entry branch kill
    applyStimulus(3'd2, 5'd20, 5'd1, 5'd11, 5'd1, 2'd0, 1'b1, 1'b0); tick();
    applyStimulus(3'd5, 5'd21, 5'd1, 5'd11, 5'd1, 2'd0, 1'b1, 1'b0); tick();
    applyStimulus(3'd2, 5'd22, 5'd1, 5'd11, 5'd1, 2'd0, 1'b1, 1'b0); tick();
    idle();
    check("t4_count3", 32'(bus.count), 3);
    bus.brkill = 8'b0000_0100;
    tick(); idle();
    check("t4_count1", 32'(bus.count), 1);
    wake(1, 5'd11); tick(); idle();
    tick();
    checkOutput("t4_survivor", 1'b1, 5'd21);
    check("t4_survivor_br", 32'(bus.iss_data[24:22]), 5);
    tick();
    checkOutput("t4_only_one", 1'b0, 5'd0);
    check("t4_count0", 32'(bus.count), 0);

    // Same-cycle wakeup at dispatch
    applyStimulus(3'd0, 5'd23, 5'd2, 5'd1, 5'd7, 2'd0, 1'b0, 1'b1);
    wake(1, 5'd7);
    tick(); idle();
    check("t5_count1", 32'(bus.count), 1);
    checkOutput("t5_not_same_cycle", 1'b0, 5'd0);
    tick(); checkOutput("t5_issue", 1'b1, 5'd23);
    tick();

    // Kill of a held output while stalled, then reset mid-burst
    applyStimulus(3'd1, 5'd24, 5'd1, 5'd1, 5'd1, 2'd0, 1'b1, 1'b1);
    tick(); idle();
    bus.stall = 1'b1;
    tick(); checkOutput("t6_held", 1'b1, 5'd24);
    tick(); checkOutput("t6_held2", 1'b1, 5'd24);
    bus.brkill = 8'b0000_0010;
    tick(); idle();
    checkOutput("t6_killed_held", 1'b0, 5'd0);
    bus.stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(3'd0, 5'(25 + k), 5'd1, 5'd1, 5'd1, 2'd0, 1'b1, 1'b1);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_iss_val", 32'(bus.iss_val), 0);
    check("t6_rst_iss_data", 32'(bus.iss_data), 0);
    check("t6_rst_count", 32'(bus.count), 0);
    check("t6_rst_rdy", 32'(bus.disp_rdy), 1);
    idle();
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("t6_after_rst_count", 32'(bus.count), 0);
    checkOutput("t6_after_rst", 1'b0, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
